// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the instruction-memory read bus and the IF/ID
// pipeline register outputs of the fetch stage.
//   imem_en / imem_addr  : read request issued by fetch (combinational)
//   imem_rdata           : memory data, valid one cycle after imem_en
//   ifid_valid / ifid_instr / ifid_pc : IF/ID register contents to decode
// master = fetch stage side, slave = memory / decode side.
interface fetch_stage_if #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16
);
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    output ifid_valid,
    output ifid_instr,
    output ifid_pc
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    input  ifid_valid,
    input  ifid_instr,
    input  ifid_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 4-bit-PC CPU.
// Drives the synchronous instruction memory with the current PC, computes
// pc_next (increment / branch / jump redirect) and holds the IF/ID register
// with stall and flush control. One read is tracked in flight and re-issued
// while decode stalls so the response is still correct on release.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   pc_current      : PC register output
//   pc_next         : value the PC register loads at the next edge
//   bus             : imem read bus + IF/ID outputs (fetch_stage_if.master)
//   branch_taken / branch_addr : taken branch and its target
//   jump / jump_addr           : jump and its target (beats branch)
//   stall           : decode cannot accept an instruction this cycle
module fetch_stage #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_current,
  output logic [PC_W-1:0]   pc_next,
  fetch_stage_if.master     bus,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_addr,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_addr,
  input  logic              stall
);

  logic               flush;
  logic [PC_W-1:0]    target;

  logic               req_valid_q,  req_valid_d;
  logic [PC_W-1:0]    req_pc_q,     req_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q,    ifid_pc_d;

  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;

  assign flush  = jump | branch_taken;
  assign target = jump ? jump_addr : branch_addr;

  // Priority: reset > flush > stall > normal.
  always_comb begin
    pc_next      = pc_current + PC_W'(1);
    imem_en      = 1'b0;
    imem_addr    = pc_current;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;

    if (reset) begin
      imem_en = 1'b0;
    end else if (flush) begin
      // Drop the in-flight response; IF/ID payload holds, only valid clears.
      pc_next      = target;
      req_valid_d  = 1'b0;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      // Re-issue the outstanding read so imem_rdata is still its data on release.
      pc_next   = pc_current;
      imem_addr = req_pc_q;
      imem_en   = req_valid_q;
    end else begin
      imem_en      = 1'b1;
      req_valid_d  = 1'b1;
      req_pc_d     = pc_current;
      ifid_valid_d = req_valid_q;
      ifid_instr_d = bus.imem_rdata;
      ifid_pc_d    = req_pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
    end else begin
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  assign bus.imem_en    = imem_en;
  assign bus.imem_addr  = imem_addr;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a PC register model
// and a one-cycle-latency instruction memory holding instr[i] = A000 + i.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pc_current;
  logic [3:0]  pc_next;
  logic        branch_taken;
  logic [3:0]  branch_addr;
  logic        jump;
  logic [3:0]  jump_addr;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if #(.PC_W(4), .INSTR_W(16)) bus ();

  fetch_stage #(.PC_W(4), .INSTR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_current   (pc_current),
    .pc_next      (pc_next),
    .bus          (bus),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_current <= '0;
    else       pc_current <= pc_next;
  end

  // Synchronous instruction memory
  always_ff @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 16'hA000 + {12'h000, bus.imem_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset away from an edge and walk the first three deliveries.
  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_addr = '0; branch_addr = '0;
    tick(); tick();
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.imem_en !== 1'b0 || pc_next !== 4'd1) begin
      failures++;
      $display("FAIL reset_state: valid=%b en=%b pc_next=%0d required valid=0 en=0 pc_next=1",
               bus.ifid_valid, bus.imem_en, pc_next);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 4'd0 || pc_next !== 4'd1) begin
      failures++;
      $display("FAIL first_issue: en=%b addr=%0d pc_next=%0d required en=1 addr=0 pc_next=1",
               bus.imem_en, bus.imem_addr, pc_next);
    end
    tick(); // edge 0
    checks++;
    if (bus.ifid_valid !== 1'b0) begin
      failures++;
      $display("FAIL edge0_valid: got %b required 0", bus.ifid_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 4'(k) || bus.ifid_instr !== 16'hA000 + 16'(k)) begin
        failures++;
        $display("FAIL seq_fetch%0d: valid=%b pc=%0d instr=%h required 1/%0d/%h",
                 k, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, k, 16'hA000 + 16'(k));
      end
    end
  endtask

  // Jump to 14 then run straight-line across the wrap.
  task automatic test_wrap();
    logic [3:0] exp_pc [4];
    exp_pc[0] = 4'd14; exp_pc[1] = 4'd15; exp_pc[2] = 4'd0; exp_pc[3] = 4'd1;
    jump = 1'b1; jump_addr = 4'd14;
    #1;
    checks++;
    if (pc_next !== 4'd14 || bus.imem_en !== 1'b0) begin
      failures++;
      $display("FAIL wrap_redirect: pc_next=%0d en=%b required 14/0", pc_next, bus.imem_en);
    end
    tick();
    jump = 1'b0;
    tick();
    #1;
    checks++;
    if (pc_current !== 4'd15 || pc_next !== 4'd0) begin
      failures++;
      $display("FAIL wrap_pc_next: pc_current=%0d pc_next=%0d required 15/0", pc_current, pc_next);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== exp_pc[k] ||
          bus.ifid_instr !== 16'hA000 + {12'h000, exp_pc[k]}) begin
        failures++;
        $display("FAIL wrap_seq%0d: valid=%b pc=%0d instr=%h required 1/%0d/%h",
                 k, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, exp_pc[k],
                 16'hA000 + {12'h000, exp_pc[k]});
      end
    end
  endtask

  // Three-cycle stall while IF/ID holds PC 5.
  task automatic test_stall();
    int n = 0;
    while (!(bus.ifid_valid === 1'b1 && bus.ifid_pc === 4'd5) && n < 20) begin
      tick(); n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL stall_reach5: ifid_pc=%0d required 5 within 20 cycles", bus.ifid_pc);
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (pc_next !== pc_current || bus.imem_addr !== 4'd6 || bus.imem_en !== 1'b1) begin
        failures++;
        $display("FAIL stall_comb%0d: pc_next=%0d pc_current=%0d addr=%0d en=%b required pc_next=pc_current addr=6 en=1",
                 k, pc_next, pc_current, bus.imem_addr, bus.imem_en);
      end
      tick();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 4'd5 || bus.ifid_instr !== 16'hA005) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b pc=%0d instr=%h required 1/5/a005",
                 k, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr);
      end
    end
    stall = 1'b0;
    for (int k = 6; k < 8; k++) begin
      tick();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 4'(k) || bus.ifid_instr !== 16'hA000 + 16'(k)) begin
        failures++;
        $display("FAIL stall_release%0d: valid=%b pc=%0d instr=%h required 1/%0d/%h",
                 k, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, k, 16'hA000 + 16'(k));
      end
    end
  endtask

  // Taken branch to 9 while pc_current = 4.
  task automatic test_branch();
    int n = 0;
    while (pc_current !== 4'd4 && n < 20) begin
      tick(); n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL branch_reach4: pc_current=%0d required 4 within 20 cycles", pc_current);
    end
    branch_taken = 1'b1; branch_addr = 4'd9;
    #1;
    checks++;
    if (pc_next !== 4'd9 || bus.imem_en !== 1'b0) begin
      failures++;
      $display("FAIL branch_pc_next: pc_next=%0d en=%b required 9/0", pc_next, bus.imem_en);
    end
    tick();
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.ifid_valid !== 1'b0) begin
        failures++;
        $display("FAIL branch_bubble%0d: valid=%b required 0", k, bus.ifid_valid);
      end
      tick();
    end
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 4'd9 || bus.ifid_instr !== 16'hA009) begin
      failures++;
      $display("FAIL branch_target: valid=%b pc=%0d instr=%h required 1/9/a009",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr);
    end
  endtask

  // Jump + branch + stall together, then a stall with no read in flight.
  task automatic test_jump_priority();
    jump = 1'b1; jump_addr = 4'd2;
    branch_taken = 1'b1; branch_addr = 4'd11;
    stall = 1'b1;
    #1;
    checks++;
    if (pc_next !== 4'd2 || bus.imem_en !== 1'b0) begin
      failures++;
      $display("FAIL jump_priority: pc_next=%0d en=%b required 2/0", pc_next, bus.imem_en);
    end
    tick();
    jump = 1'b0; branch_taken = 1'b0;
    #1;
    checks++;
    if (bus.ifid_valid !== 1'b0 || pc_current !== 4'd2 || pc_next !== 4'd2 || bus.imem_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_after_flush: valid=%b pc=%0d pc_next=%0d en=%b required 0/2/2/0",
               bus.ifid_valid, pc_current, pc_next, bus.imem_en);
    end
    tick();
    stall = 1'b0;
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b0) begin
      failures++;
      $display("FAIL jump_bubble: valid=%b required 0", bus.ifid_valid);
    end
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 4'd2 || bus.ifid_instr !== 16'hA002) begin
      failures++;
      $display("FAIL jump_target: valid=%b pc=%0d instr=%h required 1/2/a002",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr);
    end
  endtask

  // Asynchronous reset while a valid instruction is held under stall.
  task automatic test_reset_midstream();
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 4'd0 || bus.ifid_instr !== 16'h0000 ||
        bus.imem_en !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b pc=%0d instr=%h en=%b required 0/0/0000/0",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.imem_en);
    end
    stall = 1'b0;
    tick();
    reset = 1'b0;
    tick(); // edge 0
    checks++;
    if (bus.ifid_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_edge0: valid=%b required 0", bus.ifid_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 4'(k) || bus.ifid_instr !== 16'hA000 + 16'(k)) begin
        failures++;
        $display("FAIL restart_seq%0d: valid=%b pc=%0d instr=%h required 1/%0d/%h",
                 k, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, k, 16'hA000 + 16'(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_stall();
    test_branch();
    test_jump_priority();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 4-bit-PC CPU. Sits between `program_counter` and decode: it drives the synchronous instruction memory with the current PC and computes `pc_next` (increment, branch or jump redirect) for the PC register. It also holds the IF/ID pipeline register with stall and flush control. The memory has one cycle of read latency, so the block tracks one in-flight request and re-issues it while decode stalls.

## Interface
- `PC_W`, 4: PC and instruction-memory address width.
- `INSTR_W`, 16: instruction width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `pc_current` in `PC_W`: PC register output.
- `pc_next` out `PC_W`: value the PC register loads at the next edge.
- `imem_en` out 1: instruction-memory read enable.
- `imem_addr` out `PC_W`: instruction-memory read address.
- `imem_rdata` in `INSTR_W`: memory data. It is valid the cycle after `imem_en` is high and always matches the address issued in the previous cycle.
- `branch_taken` in 1: branch resolved taken (Branch & alu_zero).
- `branch_addr` in `PC_W`: branch target.
- `jump` in 1: jump instruction resolved.
- `jump_addr` in `PC_W`: jump target.
- `stall` in 1: decode cannot accept a new instruction this cycle.
- `ifid_valid` out 1: IF/ID register holds a real instruction.
- `ifid_instr` out `INSTR_W`: fetched instruction.
- `ifid_pc` out `PC_W`: address of `ifid_instr`.

## Operation
- Internal state: `req_valid` (a read was issued last cycle), `req_pc` (its address), and the IF/ID registers.
- `flush = jump | branch_taken`. Target is `jump_addr` if `jump` is high, otherwise `branch_addr` (jump has priority).
- Per-cycle priority is flush > stall > normal.
- Flush:
  - `pc_next` = target; `imem_en` = 0.
  - `req_valid` <= 0, dropping the in-flight response.
  - `ifid_valid` <= 0; `ifid_instr`/`ifid_pc` hold.
  - Flush overrides a simultaneous stall.
- Stall (no flush):
  - `pc_next` = `pc_current`.
  - `imem_addr` = `req_pc`; `imem_en` = `req_valid`. The same read is re-issued so that `imem_rdata` is correct when the stall releases.
  - `req_*` and all `ifid_*` hold.
- Normal:
  - `imem_addr` = `pc_current`; `imem_en` = 1.
  - `pc_next` = `pc_current + 1`, modulo 2^`PC_W` (15 -> 0, no carry out).
  - `req_valid` <= 1; `req_pc` <= `pc_current`.
  - `ifid_valid` <= `req_valid`; `ifid_instr` <= `imem_rdata`; `ifid_pc` <= `req_pc`.
- While `reset` is high:
  - `imem_en` = 0.
  - `pc_next` = `pc_current + 1`. This value is unused because the PC register is itself in reset.
- `ifid_instr` and `ifid_pc` are don't-care while `ifid_valid` = 0. The bench must not check them then.

## Timing
- Reset values: `req_valid` = 0, `req_pc` = 0, `ifid_valid` = 0, `ifid_instr` = 0, `ifid_pc` = 0. Asserting `reset` mid-operation clears these immediately, without waiting for a clock edge.
- Combinational outputs: `pc_next`, `imem_en`, `imem_addr`. There is no register between `pc_current` and `imem_addr`.
- Fetch latency: 2 edges, from PC value to `ifid_valid` with that instruction.
- After reset release:
  - Edge 0 issues PC 0.
  - Edge 1 sets `ifid_valid` = 1 with `ifid_pc` = 0.
  - Then one instruction is delivered per non-stalled cycle.
- Flush at edge N:
  - `ifid_valid` = 0 after N and after N+1 (two bubbles).
  - The target instruction appears after edge N+2.
- Stall:
  - Holds everything for exactly as many edges as `stall` is high.
  - No instruction is lost or duplicated.
  - Throughput returns to 1 per cycle on the first edge with `stall` low.
- A stall starting in the cycle right after a flush (`req_valid` = 0) issues no read. After release, fetch resumes from the held PC.

## Test plan
- Instruction memory model for all scenarios: `instr[i] = 16'hA000 + i`.
- Reset and sequential fetch: release reset with the PC at 0, no stall. Required: `ifid_valid` rises after edge 1 with `ifid_pc` 0 / `ifid_instr` A000, then 1/A001, 2/A002 on successive edges.
- Wrap-around: run straight-line from PC 14. Required: `ifid_pc` sequence 14, 15, 0, 1 with `ifid_instr` A00E, A00F, A000, A001; `pc_next` shows 0 when `pc_current` = 15.
- Stall: assert `stall` for 3 cycles while `ifid_pc` = 5. Required: `ifid` holds 5/A005, `pc_next` = `pc_current`, `imem_addr` = 6 each stalled cycle; after release the next outputs are 6/A006 then 7/A007, with no gap or duplicate.
- Branch flush: pulse `branch_taken` with `branch_addr` = 9 at `pc_current` = 4. Required: `pc_next` = 9 that cycle; two cycles of `ifid_valid` = 0; then 9/A009.
- Jump priority plus stall: assert `jump` (`jump_addr` = 2), `branch_taken` (`branch_addr` = 11) and `stall` together. Required: `pc_next` = 2, `ifid_valid` drops, and the next valid output is 2/A002.
- Reset mid-stream: assert `reset` asynchronously while `ifid_valid` = 1 and `stall` = 1. Required: `ifid_valid`, `ifid_pc` and `ifid_instr` clear to 0 before the next edge, `imem_en` = 0, and after release the fetch restarts from PC 0 as in the first scenario.
